// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the unified-memory port arbiter.
// master = the arbiter itself, slave = the requesters plus the memory.
interface mem_port_arbiter_if;
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic        addr_sel;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        i_ack;
    logic        d_ack;
    logic        err;

    modport master (
        input  i_req, d_req, d_we, mem_ready, mem_rdata,
        output addr_sel, mem_req, mem_we, rdata, i_ack, d_ack, err
    );

    modport slave (
        output i_req, d_req, d_we, mem_ready, mem_rdata,
        input  addr_sel, mem_req, mem_we, rdata, i_ack, d_ack, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and the MEM stage,
// with alternating tie-break, registered completion and a hung-access watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_nxt_s;
    logic        last_d_r, last_d_nxt_s;
    logic [7:0]  wait_r, wait_nxt_s;
    logic        addr_sel_r, addr_sel_nxt_s;
    logic        mem_req_r, mem_req_nxt_s;
    logic        mem_we_r, mem_we_nxt_s;
    logic        i_ack_r, i_ack_nxt_s;
    logic        d_ack_r, d_ack_nxt_s;
    logic        err_r, err_nxt_s;
    logic [31:0] rdata_r, rdata_nxt_s;

    logic i_eff_s, d_eff_s, grant_i_s, grant_d_s, tmo_s;

    // A requester is ignored in its own ack cycle so a still-high level cannot re-grant.
    assign i_eff_s   = bus.i_req & ~i_ack_r;
    assign d_eff_s   = bus.d_req & ~d_ack_r;
    assign grant_d_s = d_eff_s & (~i_eff_s | ~last_d_r);
    assign grant_i_s = i_eff_s & (~d_eff_s | last_d_r);
    assign tmo_s     = (wait_r == WAIT_LAST);

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            last_d_r   <= 1'b0;
            wait_r     <= 8'd0;
            addr_sel_r <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            i_ack_r    <= 1'b0;
            d_ack_r    <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            last_d_r   <= last_d_nxt_s;
            wait_r     <= wait_nxt_s;
            addr_sel_r <= addr_sel_nxt_s;
            mem_req_r  <= mem_req_nxt_s;
            mem_we_r   <= mem_we_nxt_s;
            i_ack_r    <= i_ack_nxt_s;
            d_ack_r    <= d_ack_nxt_s;
            err_r      <= err_nxt_s;
            rdata_r    <= rdata_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = BUSY_D;
                end else if (grant_i_s) begin
                    state_nxt_s = BUSY_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready || tmo_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, tie-break memory and watchdog.
    always_comb begin
        last_d_nxt_s   = last_d_r;
        wait_nxt_s     = wait_r;
        addr_sel_nxt_s = addr_sel_r;
        mem_req_nxt_s  = mem_req_r;
        mem_we_nxt_s   = mem_we_r;
        rdata_nxt_s    = rdata_r;
        i_ack_nxt_s    = 1'b0;
        d_ack_nxt_s    = 1'b0;
        err_nxt_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    addr_sel_nxt_s = 1'b1;
                    mem_req_nxt_s  = 1'b1;
                    mem_we_nxt_s   = bus.d_we;
                    last_d_nxt_s   = 1'b1;
                    wait_nxt_s     = 8'd0;
                end else if (grant_i_s) begin
                    addr_sel_nxt_s = 1'b0;
                    mem_req_nxt_s  = 1'b1;
                    mem_we_nxt_s   = 1'b0;
                    last_d_nxt_s   = 1'b0;
                    wait_nxt_s     = 8'd0;
                end else begin
                    mem_req_nxt_s  = 1'b0;
                    mem_we_nxt_s   = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    mem_req_nxt_s = 1'b0;
                    mem_we_nxt_s  = 1'b0;
                    rdata_nxt_s   = bus.mem_rdata;
                    i_ack_nxt_s   = (state_r == BUSY_I);
                    d_ack_nxt_s   = (state_r == BUSY_D);
                end else if (tmo_s) begin
                    // Watchdog abort: complete with err and zeroed data.
                    mem_req_nxt_s = 1'b0;
                    mem_we_nxt_s  = 1'b0;
                    rdata_nxt_s   = 32'd0;
                    err_nxt_s     = 1'b1;
                    i_ack_nxt_s   = (state_r == BUSY_I);
                    d_ack_nxt_s   = (state_r == BUSY_D);
                end else begin
                    wait_nxt_s    = wait_r + 8'd1;
                end
            end
            default: begin
                mem_req_nxt_s = 1'b0;
                mem_we_nxt_s  = 1'b0;
            end
        endcase
    end

    assign bus.addr_sel = addr_sel_r;
    assign bus.mem_req  = mem_req_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.rdata    = rdata_r;
    assign bus.i_ack    = i_ack_r;
    assign bus.d_ack    = d_ack_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-table bench for mem_port_arbiter (TIMEOUT=4): expected outputs are queued when
// inputs are driven and compared one cycle later, plus an asynchronous mid-access reset.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    mem_port_arbiter_if bus_if ();

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, we, rdy;
        logic [31:0] mrd;
        logic [37:0] exp;   // {addr_sel, mem_req, mem_we, i_ack, d_ack, err, rdata}
    } vec_t;

    typedef struct packed {
        logic [15:0] tag;
        logic [37:0] val;
    } sb_t;

    vec_t tbl[27];
    sb_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   tag_n = 0;

    function automatic vec_t mk(logic ir, logic dr, logic we, logic rdy, logic [31:0] mrd,
                                logic as_e, logic mr_e, logic mwe_e, logic [31:0] rd_e,
                                logic ia_e, logic da_e, logic er_e);
        vec_t v;
        v.ir = ir; v.dr = dr; v.we = we; v.rdy = rdy; v.mrd = mrd;
        v.exp = {as_e, mr_e, mwe_e, ia_e, da_e, er_e, rd_e};
        return v;
    endfunction

    function automatic logic [37:0] observe();
        return {bus_if.addr_sel, bus_if.mem_req, bus_if.mem_we,
                bus_if.i_ack, bus_if.d_ack, bus_if.err, bus_if.rdata};
    endfunction

    task automatic compare(string name, logic [37:0] got, logic [37:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got {as,req,we,iack,dack,err,rdata}=%h expected %h", name, got, want);
        end
    endtask

    // Drive one vector now, queue its expectation for the coming edge, then move to the next negedge.
    task automatic apply(vec_t v);
        sb_t e;
        bus_if.i_req     = v.ir;
        bus_if.d_req     = v.dr;
        bus_if.d_we      = v.we;
        bus_if.mem_ready = v.rdy;
        bus_if.mem_rdata = v.mrd;
        e.tag = 16'(tag_n);
        e.val = v.exp;
        exp_q.push_back(e);
        tag_n++;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        sb_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare($sformatf("vec%0d", e.tag), observe(), e.val);
        end
    end

    initial begin
        // reset with both requests, contention, single fetch, write, timeout, dropped request
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'h22222222, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h33333333, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0, 32'h44444444, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h44444444, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44444444, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44444444, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44444444, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b0, 32'h8C220004, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8C220004, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        tbl[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        tbl[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        tbl[22] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        tbl[24] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0);
        tbl[25] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, 32'h55AA55AA, 1'b1, 1'b0, 1'b0);
        tbl[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 1'b0);

        bus_if.i_req     = 1'b1;
        bus_if.d_req     = 1'b1;
        bus_if.d_we      = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        compare("reset_outputs", observe(), 38'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 27; i++) apply(tbl[i]);

        // Reset two cycles into BUSY_I: outputs clear at once, no ack, then regrant.
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 1'b0, 1'b0, 1'b0));
        #2 rst_n = 1'b0;
        #1 compare("rst_async", observe(), 38'h0);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 compare("rst_hold", observe(), 38'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single-ported unified memory between the instruction-fetch stage and the MEM stage of the pipelined MIPS core. It grants one requester at a time and drives the select of the 32-bit 2:1 address/write-data mux in front of the memory. It runs the request/ready handshake with the memory and returns registered read data and a one-cycle acknowledge to the winning requester. A watchdog aborts memory accesses that hang.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` stays high without `mem_ready` before the access is aborted. Legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req` in 1: fetch request; level, held until `i_ack`.
- `d_req` in 1: data request; level, held until `d_ack`.
- `d_we` in 1: data request is a write; sampled at grant.
- `addr_sel` out 1: select to the 32-bit 2:1 mux; 0 = fetch address, 1 = data address/write data.
- `mem_req` out 1: memory access strobe.
- `mem_we` out 1: memory write enable; valid while `mem_req` = 1.
- `mem_ready` in 1: memory completion; sampled only while `mem_req` = 1.
- `mem_rdata` in 32: memory read data; valid with `mem_ready`.
- `rdata` out 32: registered read data returned to the acked requester.
- `i_ack` out 1: one-cycle fetch completion pulse.
- `d_ack` out 1: one-cycle data completion pulse.
- `err` out 1: one-cycle pulse coincident with an ack when the access timed out.

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset enters IDLE.
- Reset values: `addr_sel`=0, `mem_req`=0, `mem_we`=0, `rdata`=0, `i_ack`=0, `d_ack`=0, `err`=0, `last`=I, wait counter=0.
- IDLE grant rule:
  - Each request is masked in any cycle where its own ack is high.
  - Only `d_req` effective: go to BUSY_D.
  - Only `i_req` effective: go to BUSY_I.
  - Both effective: grant the requester other than `last`. After reset `last`=I, so data wins the first tie.
  - Neither effective: stay in IDLE.
- On grant, registered for the next cycle:
  - `addr_sel` = 1 for D, 0 for I.
  - `mem_req` = 1.
  - `mem_we` = `d_we` for D, 0 for I.
  - `last` = the granted requester.
  - Wait counter cleared.
- BUSY_x: `addr_sel`, `mem_we` and `mem_req` are held stable. Each cycle:
  - `mem_ready`=1: next cycle `mem_req`=0, `mem_we`=0, x_ack=1, `rdata`=`mem_rdata`; return to IDLE.
  - Else, wait counter = TIMEOUT−1: next cycle `mem_req`=0, x_ack=1, `err`=1, `rdata`=0; return to IDLE.
  - Else: increment the wait counter.
- Writes also return `rdata` = `mem_rdata` as captured. Requesters ignore it.
- `addr_sel` keeps its last value in IDLE; it changes only on a new grant.
- A request dropped mid-access does not cancel it; the access completes and is acked.
- Counter width is 8 bits; it never wraps because the timeout fires first.

## Timing
- Grant latency: a request sampled in IDLE at edge N gives `mem_req`=1 after edge N.
- Completion: `mem_ready` sampled at edge M gives ack/`rdata` valid after edge M, for exactly one cycle.
- Minimum access: request at cycle 0, `mem_req` at cycle 1, `mem_ready` at cycle 1, ack at cycle 2. This is 2 cycles request-to-ack.
- Turnaround: in the ack cycle the arbiter is IDLE and may grant the other requester, so `mem_req` is high again in the next cycle. Back-to-back alternation gives one idle `mem_req` cycle between accesses.
- A requester must drop its req, or present a new request, in the cycle after its ack. The masking prevents a duplicate grant in the ack cycle itself.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then ack+err.
- `rst_n` low mid-access clears all outputs immediately. The access is abandoned with no ack.

## Test plan
- Reset: hold `rst_n`=0 with `i_req`=`d_req`=1 → all outputs 0. Release → `mem_req`=1, `addr_sel`=1 (data wins first tie) one cycle later.
- Single fetch: `i_req`=1, `mem_ready`=1 on the 3rd `mem_req` cycle, `mem_rdata`=0x8C220004 → `i_ack` one-cycle pulse, `rdata`=0x8C220004, `addr_sel`=0 throughout, `mem_we`=0.
- Contention: `i_req` and `d_req` held high, memory ready after 1 cycle → grants alternate D,I,D,I with `addr_sel` 1,0,1,0. No ack is repeated without a new grant.
- Data write: `d_req`=1, `d_we`=1 → `mem_we`=1 and `addr_sel`=1 for the whole access. After ready: `d_ack`=1, `mem_we`=0.
- Timeout: TIMEOUT=4, `d_req`=1, `mem_ready` stuck 0 → `mem_req` high exactly 4 cycles, then `d_ack`=1, `err`=1, `rdata`=0. Back in IDLE.
- Reset mid-access: assert `rst_n`=0 two cycles into BUSY_I → `mem_req` drops asynchronously and no `i_ack` occurs. After release, a pending `i_req` is regranted.
